// File: rtl/mcu_raster_ctrl_pkg.sv
// Shared definitions for the MCU raster controller.
//   MCU_N      : MCU edge length in pixels (rows per MCU, pixels per read word)
//   PIX_W      : pixel width in bits
//   pix_t      : one raster pixel
//   rd_state_t : read-side sequencer states
package mcu_pkg;

  localparam int MCU_N = 8;
  localparam int PIX_W = 8;

  typedef logic [PIX_W-1:0] pix_t;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } rd_state_t;

endpackage

// File: rtl/mcu_raster_ctrl.sv
// mcu_raster_ctrl
//   Sequences a raster-order pixel stream into 8x8 MCU row reads through an
//   external two-bank line buffer (each bank holds MCU_N image lines, written
//   per byte, read per MCU_N-byte word, 1-cycle read latency).
//
// Ports
//   clk, nrst            : clock (rising edge), synchronous active-low reset
//   pix_valid/pix_ready  : pixel input handshake; transfer = valid & ready
//   wr_en/wr_bank/wr_addr: byte write to the buffer, 1 cycle after transfer
//   rd_ready             : downstream accepts one MCU row this cycle
//   rd_en/rd_bank/rd_addr: word read from the buffer
//   rd_row               : row within the current MCU, aligned with rd_en
//   mcu_done             : pulses with the row-7 read of every MCU
//   frame_done           : pulses with the last read of the frame
module mcu_raster_ctrl
  import mcu_pkg::*;
#(
  parameter  int IMG_W = 64,
  parameter  int IMG_H = 64,
  localparam int WA_W  = $clog2(8 * IMG_W),
  localparam int RA_W  = $clog2(IMG_W)
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            pix_valid,
  output logic            pix_ready,
  output logic            wr_en,
  output logic            wr_bank,
  output logic [WA_W-1:0] wr_addr,
  input  logic            rd_ready,
  output logic            rd_en,
  output logic            rd_bank,
  output logic [RA_W-1:0] rd_addr,
  output logic [2:0]      rd_row,
  output logic            mcu_done,
  output logic            frame_done
);

  localparam int MCU_COLS = IMG_W / MCU_N;
  localparam int BROWS    = IMG_H / MCU_N;
  // Sized so a single block-row image still gets a 1-bit counter.
  localparam int BR_W     = $clog2(BROWS + 1);

  localparam logic [WA_W-1:0] WR_LAST  = WA_W'(MCU_N * IMG_W - 1);
  localparam logic [RA_W-1:0] COLS     = RA_W'(MCU_COLS);
  localparam logic [RA_W-1:0] COL_LAST = RA_W'(MCU_COLS - 1);
  localparam logic [2:0]      ROW_LAST = 3'(MCU_N - 1);
  localparam logic [BR_W-1:0] BR_LAST  = BR_W'(BROWS - 1);

  // Bank status and write-side counters
  logic [1:0]      full;
  logic [1:0]      full_nxt;
  logic            wr_ptr;
  logic [WA_W-1:0] wr_cnt;
  logic            xfer;
  logic            wr_last;

  // Read-side sequencer
  rd_state_t       state;
  rd_state_t       state_nxt;
  logic            rd_ptr;
  logic [2:0]      row_cnt;
  logic [RA_W-1:0] mcu_cnt;
  logic [BR_W-1:0] brow_cnt;
  logic            rd_issue;
  logic            rd_last_pos;
  logic            rd_last;

  // pix_ready looks only at registered state so it never depends on pix_valid.
  assign pix_ready   = ~full[wr_ptr];
  assign xfer        = pix_valid & pix_ready;
  assign wr_last     = xfer && (wr_cnt == WR_LAST);

  assign rd_last_pos = (row_cnt == ROW_LAST) && (mcu_cnt == COL_LAST);
  assign rd_last     = rd_issue & rd_last_pos;

  always_comb begin
    state_nxt = state;
    rd_issue  = 1'b0;
    unique case (state)
      IDLE: begin
        if (full[rd_ptr]) state_nxt = READ;
      end
      READ: begin
        rd_issue = rd_ready;
        if (rd_ready && rd_last_pos) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Writer and reader never own the same bank at once (writer needs it empty,
  // reader needs it full), so the set and clear never collide on one bit.
  always_comb begin
    full_nxt = full;
    if (wr_last) full_nxt[wr_ptr] = 1'b1;
    if (rd_last) full_nxt[rd_ptr] = 1'b0;
  end

  // Write stage: registered strobe one cycle after the transfer
  always_ff @(posedge clk) begin
    if (!nrst) begin
      full    <= 2'b00;
      wr_ptr  <= 1'b0;
      wr_cnt  <= '0;
      wr_en   <= 1'b0;
      wr_bank <= 1'b0;
      wr_addr <= '0;
    end else begin
      full  <= full_nxt;
      wr_en <= xfer;
      if (xfer) begin
        wr_bank <= wr_ptr;
        wr_addr <= wr_cnt;
        if (wr_last) begin
          wr_cnt <= '0;
          wr_ptr <= ~wr_ptr;
        end else begin
          wr_cnt <= wr_cnt + 1'b1;
        end
      end
    end
  end

  // Read stage: mcu index is the outer loop, row the inner loop
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state      <= IDLE;
      rd_ptr     <= 1'b0;
      row_cnt    <= '0;
      mcu_cnt    <= '0;
      brow_cnt   <= '0;
      rd_en      <= 1'b0;
      rd_bank    <= 1'b0;
      rd_addr    <= '0;
      rd_row     <= '0;
      mcu_done   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      rd_en      <= rd_issue;
      mcu_done   <= rd_issue && (row_cnt == ROW_LAST);
      frame_done <= rd_last && (brow_cnt == BR_LAST);
      if (rd_issue) begin
        rd_bank <= rd_ptr;
        rd_addr <= RA_W'(row_cnt) * COLS + mcu_cnt;
        rd_row  <= row_cnt;
        row_cnt <= row_cnt + 1'b1;
        if (row_cnt == ROW_LAST) begin
          mcu_cnt <= (mcu_cnt == COL_LAST) ? '0 : mcu_cnt + 1'b1;
        end
      end
      if (rd_last) begin
        rd_ptr   <= ~rd_ptr;
        brow_cnt <= (brow_cnt == BR_LAST) ? '0 : brow_cnt + 1'b1;
      end
    end
  end

endmodule
